fp_divider_seq: RTL and testbench

//  Iterative IEEE-754 single-precision divider, q = a / b. Counterpart to the

---
 rtl/fp_divider_seq.sv | 189 ++++++++++++++++++
 tb/tb_fp_divider_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_divider_seq.sv
// Iterative IEEE-754 single-precision divider (q = a / b): one restoring quotient
// bit per cycle, round-to-nearest-even, flush-to-zero, valid/ready handshakes.
module fp_divider_seq #(
  parameter int                   EXP_W = 8,
  parameter int                   MAN_W = 23,
  parameter logic [EXP_W+MAN_W:0] QNAN  = 32'h7FC00000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   q,
  output logic                   U,
  output logic                   O,
  output logic                   N,
  output logic                   Z
);

  localparam int W     = EXP_W + MAN_W + 1;
  localparam int BIAS  = 2**(EXP_W-1) - 1;
  localparam int SIG_W = MAN_W + 1;
  localparam int QUO_W = MAN_W + 3;
  localparam int EW    = EXP_W + 2;
  localparam int CNT_W = $clog2(QUO_W);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_DONE} state_t;

  state_t           r_state, w_next_state;
  logic [W-1:0]     r_a, r_b, r_q;
  logic             r_sign, r_out_valid;
  logic             r_u, r_o, r_n, r_z;
  logic [EW-1:0]    r_exp;
  logic [SIG_W-1:0] r_div;
  logic [SIG_W:0]   r_rem;
  logic [QUO_W-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;

  // Operand classification (denormals count as zero)
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_man, w_b_man;
  logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_special, w_sign;
  logic [EW-1:0]    w_e_unpack;

  assign w_a_exp   = r_a[MAN_W +: EXP_W];
  assign w_b_exp   = r_b[MAN_W +: EXP_W];
  assign w_a_man   = r_a[MAN_W-1:0];
  assign w_b_man   = r_b[MAN_W-1:0];
  assign w_sign    = r_a[W-1] ^ r_b[W-1];
  assign w_a_zero  = (w_a_exp == '0);
  assign w_b_zero  = (w_b_exp == '0);
  assign w_a_inf   = (w_a_exp == EXP_ONES) && (w_a_man == '0);
  assign w_b_inf   = (w_b_exp == EXP_ONES) && (w_b_man == '0);
  assign w_a_nan   = (w_a_exp == EXP_ONES) && (w_a_man != '0);
  assign w_b_nan   = (w_b_exp == EXP_ONES) && (w_b_man != '0);
  assign w_special = w_a_zero | w_b_zero | w_a_inf | w_b_inf | w_a_nan | w_b_nan;
  assign w_e_unpack = EW'(w_a_exp) - EW'(w_b_exp) + EW'(BIAS);

  logic [W-1:0] w_spec_q;
  logic         w_spec_n, w_spec_z;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_spec_q = {w_sign, {(W-1){1'b0}}};
    w_spec_n = 1'b0;
    w_spec_z = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_q = QNAN;
      w_spec_n = 1'b1;
    end else if (w_a_inf) begin
      w_spec_q = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_b_zero) begin
      w_spec_q = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
      w_spec_z = 1'b1;
    end
  end

  // Restoring division step
  logic             w_ge;
  logic [SIG_W:0]   w_rem_sub, w_rem_next;
  assign w_ge       = (r_rem >= {1'b0, r_div});
  assign w_rem_sub  = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;
  assign w_rem_next = w_rem_sub << 1;

  // Normalise, round to nearest even, range check
  logic [MAN_W-1:0] w_frac_pre, w_frac;
  logic             w_guard, w_sticky, w_round_up, w_carry, w_ovf, w_unf;
  logic [EW-1:0]    w_e_norm, w_e_fin;
  logic [W-1:0]     w_rnd_q;

  always_comb begin
    w_frac_pre = r_quo[QUO_W-2 -: MAN_W];
    w_guard    = r_quo[1];
    w_sticky   = r_quo[0] | (|r_rem);
    w_e_norm   = r_exp;
    if (!r_quo[QUO_W-1]) begin
      w_frac_pre = r_quo[QUO_W-3 -: MAN_W];
      w_guard    = r_quo[0];
      w_sticky   = |r_rem;
      w_e_norm   = r_exp - EW'(1);
    end
    w_round_up          = w_guard & (w_sticky | w_frac_pre[0]);
    {w_carry, w_frac}   = {1'b0, w_frac_pre} + (MAN_W+1)'(w_round_up);
    w_e_fin             = w_carry ? (w_e_norm + EW'(1)) : w_e_norm;
    w_ovf   = !w_e_fin[EW-1] && (w_e_fin >= EW'(2**EXP_W - 1));
    w_unf   = w_e_fin[EW-1] || (w_e_fin == '0);
    w_rnd_q = {r_sign, w_e_fin[EXP_W-1:0], w_frac};
    if (w_ovf)      w_rnd_q = {r_sign, EXP_ONES, {MAN_W{1'b0}}};
    else if (w_unf) w_rnd_q = {r_sign, {(W-1){1'b0}}};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = S_UNPACK;
      end
      S_UNPACK: w_next_state = w_special ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (r_cnt == CNT_W'(QUO_W-1)) w_next_state = S_ROUND;
      S_ROUND:  w_next_state = S_DONE;
      S_DONE:   if (r_out_valid && out_ready) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // NOTE: iteration registers are reset as well, so an aborted op leaves no partial state behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0; r_b <= '0; r_q <= '0; r_sign <= 1'b0; r_out_valid <= 1'b0;
      r_u <= 1'b0; r_o <= 1'b0; r_n <= 1'b0; r_z <= 1'b0;
      r_exp <= '0; r_div <= '0; r_rem <= '0; r_quo <= '0; r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a <= a;
          r_b <= b;
        end
        S_UNPACK: begin
          r_sign <= w_sign;
          if (w_special) begin
            r_q <= w_spec_q;
            r_u <= 1'b0; r_o <= 1'b0; r_n <= w_spec_n; r_z <= w_spec_z;
          end else begin
            r_div <= {1'b1, w_b_man};
            r_rem <= {2'b01, w_a_man};
            r_quo <= '0;
            r_exp <= w_e_unpack;
            r_cnt <= '0;
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[QUO_W-2:0], w_ge};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_ROUND: begin
          r_q <= w_rnd_q;
          r_u <= w_unf; r_o <= w_ovf; r_n <= 1'b0; r_z <= 1'b0;
        end
        S_DONE: begin
          // Result registered on DONE entry; out_valid follows one cycle later
          if (!r_out_valid)    r_out_valid <= 1'b1;
          else if (out_ready)  r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign q         = r_q;
  assign U         = r_u;
  assign O         = r_o;
  assign N         = r_n;
  assign Z         = r_z;

endmodule

// File: tb/tb_fp_divider_seq.sv
// Directed testbench for fp_divider_seq: normal quotients, rounding, specials,
// range flags, output backpressure and reset abort, all with hand-computed results.
module tb_fp_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic        U, O, N, Z;
  logic [31:0] a, b, q;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fp_divider_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .U(U), .O(O), .N(N), .Z(Z)
  );

  // Issues one op; lat counts clock edges from acceptance to out_valid high.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        output logic [31:0] rq, output logic [3:0] rf, output int lat);
    @(negedge clk);
    in_valid = 1'b1; a = ia; b = ib;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL run_op_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL run_op_timeout: out_valid=%b after %0d cycles", out_valid, lat);
    end
    rq = q;
    rf = {U, O, N, Z};
  endtask

  task automatic drain();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL reset_q: got %h expected 00000000", q); end
    checks++;
    if ({U, O, N, Z} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {U, O, N, Z});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_normal();
    logic [31:0] va [3] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000};
    logic [31:0] vb [3] = '{32'h40000000, 32'h40400000, 32'h40000000};
    logic [31:0] vq [3] = '{32'h40400000, 32'h3EAAAAAB, 32'hC0400000};
    logic [31:0] rq;
    logic [3:0]  rf;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], rq, rf, lat);
      checks++;
      if (rq !== vq[i]) begin errors++; $display("FAIL normal_q[%0d]: got %h expected %h", i, rq, vq[i]); end
      checks++;
      if (rf !== 4'b0000) begin errors++; $display("FAIL normal_flags[%0d]: got %b expected 0000", i, rf); end
      checks++;
      if (lat != 29) begin errors++; $display("FAIL normal_latency[%0d]: got %0d expected 29", i, lat); end
      drain();
    end
  endtask

  task automatic test_special();
    // flags are {U,O,N,Z}
    logic [31:0] va [6] = '{32'h3F800000, 32'h00000000, 32'hFF800000,
                            32'h7FC00001, 32'h3F800000, 32'hBF800000};
    logic [31:0] vb [6] = '{32'h00000000, 32'h00000000, 32'h40000000,
                            32'h3F800000, 32'h7F800000, 32'h7F800000};
    logic [31:0] vq [6] = '{32'h7F800000, 32'h7FC00000, 32'hFF800000,
                            32'h7FC00000, 32'h00000000, 32'h80000000};
    logic [3:0]  vf [6] = '{4'b0001, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    logic [31:0] rq;
    logic [3:0]  rf;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], rq, rf, lat);
      checks++;
      if (rq !== vq[i]) begin errors++; $display("FAIL special_q[%0d]: got %h expected %h", i, rq, vq[i]); end
      checks++;
      if (rf !== vf[i]) begin errors++; $display("FAIL special_flags[%0d]: got %b expected %b", i, rf, vf[i]); end
      checks++;
      if (lat != 2) begin errors++; $display("FAIL special_latency[%0d]: got %0d expected 2", i, lat); end
      drain();
    end
  endtask

  task automatic test_range();
    logic [31:0] va [2] = '{32'h7F000000, 32'h00800000};
    logic [31:0] vb [2] = '{32'h3E800000, 32'h40000000};
    logic [31:0] vq [2] = '{32'h7F800000, 32'h00000000};
    logic [3:0]  vf [2] = '{4'b0100, 4'b1000};
    logic [31:0] rq;
    logic [3:0]  rf;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      run_op(va[i], vb[i], rq, rf, lat);
      checks++;
      if (rq !== vq[i]) begin errors++; $display("FAIL range_q[%0d]: got %h expected %h", i, rq, vq[i]); end
      checks++;
      if (rf !== vf[i]) begin errors++; $display("FAIL range_flags[%0d]: got %b expected %b", i, rf, vf[i]); end
      drain();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rq;
    logic [3:0]  rf;
    int          lat;
    run_op(32'h40C00000, 32'h40000000, rq, rf, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || q !== 32'h40400000 || {U, O, N, Z} !== 4'b0000) begin
        errors++;
        $display("FAIL hold_output[%0d]: got valid=%b q=%h flags=%b expected 1 40400000 0000",
                 i, out_valid, q, {U, O, N, Z});
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready); end
      in_valid = i[0]; a = 32'h3F800000; b = 32'h3F800000;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL release_same_cycle: in_ready got %b expected 0", in_ready); end
    @(posedge clk);
    @(negedge clk); out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL release_next_cycle: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL release_idle: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rq;
    logic [3:0]  rf;
    int          lat;
    @(negedge clk);
    in_valid = 1'b1; a = 32'h40C00000; b = 32'h40000000;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_busy: in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_reset: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL abort_q: got %h expected 00000000", q); end
    @(negedge clk); rst_n = 1'b1;
    run_op(32'h3F800000, 32'h3F800000, rq, rf, lat);
    checks++;
    if (rq !== 32'h3F800000) begin errors++; $display("FAIL abort_next_q: got %h expected 3F800000", rq); end
    checks++;
    if (rf !== 4'b0000) begin errors++; $display("FAIL abort_next_flags: got %b expected 0000", rf); end
    checks++;
    if (lat != 29) begin errors++; $display("FAIL abort_next_latency: got %0d expected 29", lat); end
    drain();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_backpressure();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
